// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: opcode/func fields, ALU operation codes,
// FSM states and the packed datapath control vector.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_MUL = 3'd6,
    ALU_DIV = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_DECODE   = 3'd0,
    ST_MD_START = 3'd1,
    ST_MD_WAIT  = 3'd2,
    ST_MD_WRITE = 3'd3,
    ST_LW_READ  = 3'd4
  } state_e;

  typedef struct packed {
    logic    mem_to_reg;
    logic    mem_write_en;
    logic    reg_write_en;
    logic    alu_reset;
    logic    imm_sl;
    logic    br_sl;
    logic    reg_dest;
    logic    jump_sl;
    logic    breq_sl;
    logic    jump_reg_sl;
    logic    instr_stall_sl;
    logic    hi_lo_sl;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the fetch/datapath side (master) and the control unit (slave):
// instruction fields and ALU handshake in, datapath selects/enables out.
interface control_unit_if;

  logic [5:0]  op_code;
  logic [5:0]  func;
  logic        alu_ready;
  logic        mem_to_reg;
  logic        mem_write_en;
  logic        reg_write_en;
  logic        alu_reset;
  logic        imm_sl;
  logic        br_sl;
  logic        reg_dest;
  logic        jump_sl;
  logic        breq_sl;
  logic        jump_reg_sl;
  logic        instr_stall_sl;
  logic        hi_lo_sl;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [15:0] perf_stall_cnt;

  modport master (
    output op_code, func, alu_ready,
    input  mem_to_reg, mem_write_en, reg_write_en, alu_reset, imm_sl, br_sl, reg_dest,
           jump_sl, breq_sl, jump_reg_sl, instr_stall_sl, hi_lo_sl, alu_op, illegal,
           perf_stall_cnt
  );

  modport slave (
    input  op_code, func, alu_ready,
    output mem_to_reg, mem_write_en, reg_write_en, alu_reset, imm_sl, br_sl, reg_dest,
           jump_sl, breq_sl, jump_reg_sl, instr_stall_sl, hi_lo_sl, alu_op, illegal,
           perf_stall_cnt
  );

endinterface

// File: rtl/ctrl_decoder.sv
// Pure combinational instruction decode: op_code/func to control vector, plus flags
// that tell the sequencer an instruction needs the MULT/DIV or LW multi-cycle path.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] op_code_i,
  input  logic [5:0] func_i,
  output ctrl_t      ctrl_o,
  output logic       is_md_o,
  output logic       is_lw_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    is_md_o       = 1'b0;
    is_lw_o       = 1'b0;
    illegal_o     = 1'b0;
    case (op_code_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD: begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_ADD; end
          FN_SUB: begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_SUB; end
          FN_AND: begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_AND; end
          FN_OR:  begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_OR;  end
          FN_SLL: begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_SLL; end
          FN_SRL: begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_SRL; end
          FN_JR:  begin ctrl_o.jump_sl = 1'b1; ctrl_o.jump_reg_sl = 1'b1; end
          FN_MULT, FN_DIV: begin
            // Issue cycle: reset the iterative ALU and hold the PC.
            is_md_o               = 1'b1;
            ctrl_o.alu_reset      = 1'b1;
            ctrl_o.instr_stall_sl = 1'b1;
            ctrl_o.alu_op         = (func_i == FN_DIV) ? ALU_DIV : ALU_MUL;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI: begin ctrl_o.imm_sl = 1'b1; ctrl_o.reg_dest = 1'b1; ctrl_o.reg_write_en = 1'b1; end
      OP_ANDI: begin
        ctrl_o.imm_sl = 1'b1; ctrl_o.reg_dest = 1'b1; ctrl_o.reg_write_en = 1'b1;
        ctrl_o.alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctrl_o.imm_sl = 1'b1; ctrl_o.reg_dest = 1'b1; ctrl_o.reg_write_en = 1'b1;
        ctrl_o.alu_op = ALU_OR;
      end
      OP_SW:  begin ctrl_o.imm_sl = 1'b1; ctrl_o.mem_write_en = 1'b1; end
      OP_BEQ: begin ctrl_o.br_sl = 1'b1; ctrl_o.breq_sl = 1'b1; ctrl_o.alu_op = ALU_SUB; end
      OP_BNE: begin ctrl_o.br_sl = 1'b1; ctrl_o.alu_op = ALU_SUB; end
      OP_J:   ctrl_o.jump_sl = 1'b1;
      OP_JAL: begin ctrl_o.jump_sl = 1'b1; ctrl_o.reg_write_en = 1'b1; end
      OP_LW: begin
        // Address goes out this cycle; the synchronous memory answers next cycle.
        is_lw_o               = 1'b1;
        ctrl_o.instr_stall_sl = 1'b1;
        ctrl_o.imm_sl         = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit: same-cycle decode for single-cycle ops, FSM sequencing for MULT/DIV and LW.
// Optional stall-cycle performance counter enabled by defining CTRL_PERF_CNT_EN.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 256
) (
  input logic           clock,
  input logic           reset,
  control_unit_if.slave bus
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  ctrl_t   dec_ctrl;
  logic    dec_md;
  logic    dec_lw;
  logic    dec_illegal;
  state_e  state_q;
  alu_op_e md_op_q;
  logic [7:0] cnt_q;
  logic    md_timeout;
  ctrl_t   out_c;
  logic    illegal_c;

  ctrl_decoder u_decoder (
    .op_code_i (bus.op_code),
    .func_i    (bus.func),
    .ctrl_o    (dec_ctrl),
    .is_md_o   (dec_md),
    .is_lw_o   (dec_lw),
    .illegal_o (dec_illegal)
  );

  assign md_timeout = (state_q == ST_MD_WAIT) && !bus.alu_ready && (cnt_q == LAST_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_DECODE;
      md_op_q <= ALU_ADD;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_DECODE: begin
          if (dec_md) begin
            state_q <= ST_MD_START;
            md_op_q <= dec_ctrl.alu_op;
          end else if (dec_lw) begin
            state_q <= ST_LW_READ;
          end
        end
        ST_MD_START: begin
          state_q <= ST_MD_WAIT;
          cnt_q   <= '0;
        end
        ST_MD_WAIT: begin
          if (bus.alu_ready)   state_q <= ST_MD_WRITE;
          else if (md_timeout) state_q <= ST_DECODE;
          else                 cnt_q   <= cnt_q + 8'd1;
        end
        ST_MD_WRITE: state_q <= ST_DECODE;
        ST_LW_READ:  state_q <= ST_DECODE;
        default:     state_q <= ST_DECODE;
      endcase
    end
  end

  // On timeout the stall drops in the aborting cycle so the PC moves past the faulty op.
  always_comb begin
    out_c        = '0;
    out_c.alu_op = ALU_ADD;
    illegal_c    = 1'b0;
    case (state_q)
      ST_DECODE: begin
        out_c     = dec_ctrl;
        illegal_c = dec_illegal;
      end
      ST_MD_START: begin
        out_c.instr_stall_sl = 1'b1;
        out_c.alu_op         = md_op_q;
      end
      ST_MD_WAIT: begin
        out_c.instr_stall_sl = !md_timeout;
        out_c.alu_op         = md_op_q;
        illegal_c            = md_timeout;
      end
      ST_MD_WRITE: begin
        out_c.hi_lo_sl     = 1'b1;
        out_c.reg_write_en = 1'b1;
        out_c.alu_op       = md_op_q;
      end
      ST_LW_READ: begin
        out_c.imm_sl       = 1'b1;
        out_c.mem_to_reg   = 1'b1;
        out_c.reg_dest     = 1'b1;
        out_c.reg_write_en = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      out_c        = '0;
      out_c.alu_op = ALU_ADD;
      illegal_c    = 1'b0;
    end
  end

  assign bus.mem_to_reg     = out_c.mem_to_reg;
  assign bus.mem_write_en   = out_c.mem_write_en;
  assign bus.reg_write_en   = out_c.reg_write_en;
  assign bus.alu_reset      = out_c.alu_reset;
  assign bus.imm_sl         = out_c.imm_sl;
  assign bus.br_sl          = out_c.br_sl;
  assign bus.reg_dest       = out_c.reg_dest;
  assign bus.jump_sl        = out_c.jump_sl;
  assign bus.breq_sl        = out_c.breq_sl;
  assign bus.jump_reg_sl    = out_c.jump_reg_sl;
  assign bus.instr_stall_sl = out_c.instr_stall_sl;
  assign bus.hi_lo_sl       = out_c.hi_lo_sl;
  assign bus.alu_op         = out_c.alu_op;
  assign bus.illegal        = illegal_c;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (out_c.instr_stall_sl && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver expands each instruction into its
// expected per-cycle control vectors; a negedge monitor pops and compares them.
module tb_control_unit;

  localparam int TB_MAX_WAIT = 6;

  // Expected-vector bit masks: {controls[11:0] as listed, alu_op[2:0], illegal}.
  localparam logic [15:0] M2R  = 16'h8000;
  localparam logic [15:0] MWE  = 16'h4000;
  localparam logic [15:0] RWE  = 16'h2000;
  localparam logic [15:0] ARST = 16'h1000;
  localparam logic [15:0] IMM  = 16'h0800;
  localparam logic [15:0] BR   = 16'h0400;
  localparam logic [15:0] RDST = 16'h0200;
  localparam logic [15:0] JMP  = 16'h0100;
  localparam logic [15:0] BEQ  = 16'h0080;
  localparam logic [15:0] JRS  = 16'h0040;
  localparam logic [15:0] STL  = 16'h0020;
  localparam logic [15:0] HL   = 16'h0010;
  localparam logic [15:0] ILL  = 16'h0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [16:0] exp_q [$];
  logic [15:0] single_tbl [logic [11:0]];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [15:0] alu(input int a);
    return 16'(a) << 1;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [11:0] tbl_key(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) ? {op, fn} : {op, 6'h00};
  endfunction

  function automatic logic [15:0] lookup(input logic [5:0] op, input logic [5:0] fn);
    logic [11:0] k;
    k = tbl_key(op, fn);
    if (single_tbl.exists(k)) return single_tbl[k];
    return ILL;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic rst, input logic [15:0] exp);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.op_code   = op;
    bus.func      = fn;
    bus.alu_ready = rdy;
    exp_q.push_back({rst, exp});
  endtask

  // k: MD_WAIT cycle (1-based) on which alu_ready rises; 0 means it never does.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int k);
    logic [15:0] a;
    if (op == 6'h23) begin
      drive(op, fn, rnd(), 1'b0, STL | IMM | alu(0));
      drive(op, fn, rnd(), 1'b0, IMM | M2R | RDST | RWE | alu(0));
    end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      a = alu((fn == 6'h18) ? 6 : 7);
      drive(op, fn, rnd(), 1'b0, ARST | STL | a);
      drive(op, fn, rnd(), 1'b0, STL | a);
      for (int w = 1; w <= TB_MAX_WAIT; w++) begin
        if (k == w) begin
          drive(op, fn, 1'b1, 1'b0, STL | a);
          drive(op, fn, rnd(), 1'b0, HL | RWE | a);
          break;
        end else if (w == TB_MAX_WAIT) begin
          drive(op, fn, 1'b0, 1'b0, ILL | a);
        end else begin
          drive(op, fn, 1'b0, 1'b0, STL | a);
        end
      end
    end else begin
      drive(op, fn, rnd(), 1'b0, lookup(op, fn));
    end
    $display("[TB] instr op=%02h fn=%02h ready_at=%0d", op, fn, k);
  endtask

  task automatic run_md_reset(input logic [5:0] fn, input int nw);
    logic [15:0] a;
    a = alu((fn == 6'h18) ? 6 : 7);
    drive(6'h00, fn, rnd(), 1'b0, ARST | STL | a);
    drive(6'h00, fn, rnd(), 1'b0, STL | a);
    repeat (nw) drive(6'h00, fn, 1'b0, 1'b0, STL | a);
    drive(6'h00, fn, rnd(), 1'b1, 16'h0000);
    $display("[TB] instr op=00 fn=%02h reset after %0d wait cycles", fn, nw);
  endtask

  // Monitor: one comparison of the control vector per cycle, plus the stall counter.
  initial begin : monitor
    logic [16:0] item;
    logic [15:0] act;
    logic [15:0] perf_model;
    logic [15:0] exp_perf;
    int cyc;
    perf_model = 16'd0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        act = {bus.mem_to_reg, bus.mem_write_en, bus.reg_write_en, bus.alu_reset, bus.imm_sl,
               bus.br_sl, bus.reg_dest, bus.jump_sl, bus.breq_sl, bus.jump_reg_sl,
               bus.instr_stall_sl, bus.hi_lo_sl, bus.alu_op, bus.illegal};
        tests_run++;
        if (act !== item[15:0]) begin
          tests_failed++;
          $display("FAIL ctrl_vector cycle %0d: got %04h expected %04h", cyc, act, item[15:0]);
        end
        if (!item[16]) begin
`ifdef CTRL_PERF_CNT_EN
          exp_perf = perf_model;
`else
          exp_perf = 16'd0;
`endif
          tests_run++;
          if (bus.perf_stall_cnt !== exp_perf) begin
            tests_failed++;
            $display("FAIL perf_stall_cnt cycle %0d: got %0d expected %0d",
                     cyc, bus.perf_stall_cnt, exp_perf);
          end
        end
        if (item[16]) perf_model = 16'd0;
        else if ((item[15:0] & STL) != 16'h0 && perf_model != 16'hFFFF) perf_model++;
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [5:0] pairs [15][2];
    int idx;
    logic [5:0] op;
    logic [5:0] fn;

    single_tbl[{6'h00, 6'h20}] = RWE | alu(0);
    single_tbl[{6'h00, 6'h22}] = RWE | alu(1);
    single_tbl[{6'h00, 6'h24}] = RWE | alu(2);
    single_tbl[{6'h00, 6'h25}] = RWE | alu(3);
    single_tbl[{6'h00, 6'h00}] = RWE | alu(4);
    single_tbl[{6'h00, 6'h02}] = RWE | alu(5);
    single_tbl[{6'h00, 6'h08}] = JMP | JRS;
    single_tbl[{6'h08, 6'h00}] = IMM | RDST | RWE | alu(0);
    single_tbl[{6'h0C, 6'h00}] = IMM | RDST | RWE | alu(2);
    single_tbl[{6'h0D, 6'h00}] = IMM | RDST | RWE | alu(3);
    single_tbl[{6'h2B, 6'h00}] = IMM | MWE | alu(0);
    single_tbl[{6'h04, 6'h00}] = BR | BEQ | alu(1);
    single_tbl[{6'h05, 6'h00}] = BR | alu(1);
    single_tbl[{6'h02, 6'h00}] = JMP;
    single_tbl[{6'h03, 6'h00}] = JMP | RWE;

    pairs = '{'{6'h00, 6'h20}, '{6'h00, 6'h22}, '{6'h00, 6'h24}, '{6'h00, 6'h25},
              '{6'h00, 6'h00}, '{6'h00, 6'h02}, '{6'h00, 6'h08}, '{6'h08, 6'h00},
              '{6'h0C, 6'h00}, '{6'h0D, 6'h00}, '{6'h2B, 6'h00}, '{6'h04, 6'h00},
              '{6'h05, 6'h00}, '{6'h02, 6'h00}, '{6'h03, 6'h00}};

    reset = 1'b1;
    bus.op_code = 6'h00;
    bus.func = 6'h20;
    bus.alu_ready = 1'b0;

    drive(6'h00, 6'h20, 1'b1, 1'b1, 16'h0000);
    drive(6'h00, 6'h20, 1'b1, 1'b1, 16'h0000);

    run_instr(6'h00, 6'h20, 0);             // ADD right after reset
    run_instr(6'h00, 6'h18, 5);             // MULT, ready on 5th wait cycle
    run_instr(6'h23, 6'h11, 0);             // LW
    run_instr(6'h05, 6'h00, 0);             // BNE
    run_instr(6'h03, 6'h00, 0);             // JAL
    run_instr(6'h00, 6'h1A, 0);             // DIV timeout
    run_md_reset(6'h18, 3);                 // reset during MD_WAIT
    run_instr(6'h00, 6'h20, 0);
    run_instr(6'h3F, 6'h15, 0);             // undecodable opcode
    run_instr(6'h00, 6'h3F, 0);             // undecodable R-type func
    run_instr(6'h00, 6'h1A, 1);             // minimum latency
    run_instr(6'h00, 6'h18, TB_MAX_WAIT);   // ready on the last allowed cycle
    run_instr(6'h04, 6'h00, 0);
    run_instr(6'h00, 6'h08, 0);
    run_instr(6'h2B, 6'h00, 0);

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 19);
      if (idx < 15) begin
        op = pairs[idx][0];
        fn = pairs[idx][1];
      end else if (idx == 15) begin
        op = 6'h23; fn = 6'($urandom);
      end else if (idx == 16) begin
        op = 6'h00; fn = 6'h18;
      end else if (idx == 17) begin
        op = 6'h00; fn = 6'h1A;
      end else begin
        op = 6'($urandom); fn = 6'($urandom);
      end
      if ($urandom_range(0, 39) == 0) run_md_reset(($urandom_range(0, 1) == 0) ? 6'h18 : 6'h1A,
                                                   $urandom_range(0, TB_MAX_WAIT - 1));
      run_instr(op, fn, $urandom_range(0, TB_MAX_WAIT));
    end

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
